// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the GRF writeback arbiter: register-file geometry and
// well-known writeback source indices.
package wb_arbiter_pkg;

  localparam int GRF_ADDR_W = 5;
  localparam int GRF_ZERO   = 0;

  localparam logic [2:0] WB_SRC_PIPE = 3'd0;
  localparam logic [2:0] WB_SRC_MLU  = 3'd1;
  localparam logic [2:0] WB_SRC_CP0  = 3'd2;

  // Late producers rotate over 1..n_src-1; index 0 never enters the rotation.
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n_src);
    return (int'(idx) >= n_src - 1) ? WB_SRC_MLU : idx + 3'd1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO holding {address, data} entries with wrap-bit pointers.
// With WB_SCOREBOARD_EN it also exposes per-entry valid bits and addresses.
module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [ADDR_W-1:0]   push_adr,
  input  logic [DATA_W-1:0]   push_data,
  output logic [ADDR_W-1:0]   head_adr,
  output logic [DATA_W-1:0]   head_data,
  output logic                full,
  output logic                empty
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [DEPTH-1:0]        entry_valid,
  output logic [DEPTH*ADDR_W-1:0] entry_adr
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] adr_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_adr  = adr_mem[rd_ptr[IDX_W-1:0]];
  assign head_data = data_mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: only slots between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      adr_mem[wr_ptr[IDX_W-1:0]]  <= push_adr;
      data_mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] slot_off;

  assign count = wr_ptr - rd_ptr;

  always_comb begin
    entry_valid = '0;
    entry_adr   = '0;
    slot_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = IDX_W'(i) - rd_ptr[IDX_W-1:0];
      entry_valid[i] = ({1'b0, slot_off} < count);
      entry_adr[i*ADDR_W +: ADDR_W] = adr_mem[i];
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// GRF writeback arbiter: N_SRC buffered producers merged onto one registered write port.
// Optional WB_SCOREBOARD_EN adds the pending_mask output for the hazard unit.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*ADDR_W-1:0] src_adr,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic                    regw_enable,
  output logic [ADDR_W-1:0]       regw_adr,
  output logic [DATA_W-1:0]       reg_write,
  output logic [2:0]              wb_src
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [(2**ADDR_W)-1:0]  pending_mask
`endif
);

  logic [N_SRC-1:0]  fifo_full;
  logic [N_SRC-1:0]  fifo_empty;
  logic [N_SRC-1:0]  fifo_push;
  logic [N_SRC-1:0]  fifo_pop;
  logic [ADDR_W-1:0] head_adr  [N_SRC];
  logic [DATA_W-1:0] head_data [N_SRC];
  logic [2:0]        rr_ptr;
  logic              grant_valid;
  logic [2:0]        grant_idx;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_data;
  logic [7:0]        empty_pad;
  int                cand;

`ifdef WB_SCOREBOARD_EN
  logic [DEPTH-1:0]        entry_valid [N_SRC];
  logic [DEPTH*ADDR_W-1:0] entry_adr   [N_SRC];
`endif

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    // Writes to r0 complete the handshake but are never queued.
    assign src_ready[i] = !fifo_full[i] && !flush && reset;
    assign fifo_push[i] = src_valid[i] && src_ready[i] &&
                          (src_adr[i*ADDR_W +: ADDR_W] != ADDR_W'(GRF_ZERO));
    assign fifo_pop[i]  = grant_valid && (grant_idx == 3'(i)) && !flush;

    wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .push        (fifo_push[i]),
      .pop         (fifo_pop[i]),
      .push_adr    (src_adr[i*ADDR_W +: ADDR_W]),
      .push_data   (src_data[i*DATA_W +: DATA_W]),
      .head_adr    (head_adr[i]),
      .head_data   (head_data[i]),
      .full        (fifo_full[i]),
      .empty       (fifo_empty[i])
`ifdef WB_SCOREBOARD_EN
      ,
      .entry_valid (entry_valid[i]),
      .entry_adr   (entry_adr[i])
`endif
    );
  end

  // Source 0 wins outright; late producers are scanned starting at rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = WB_SRC_PIPE;
    cand        = 0;
    empty_pad   = '1;
    empty_pad[N_SRC-1:0] = fifo_empty;
    if (!empty_pad[WB_SRC_PIPE]) begin
      grant_valid = 1'b1;
    end else begin
      for (int j = 0; j < N_SRC - 1; j++) begin
        cand = int'(rr_ptr) + j;
        if (cand > N_SRC - 1) cand = cand - (N_SRC - 1);
        if (!grant_valid && !empty_pad[cand[2:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[2:0];
        end
      end
    end
  end

  always_comb begin
    sel_adr  = '0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_idx == 3'(i)) begin
        sel_adr  = head_adr[i];
        sel_data = head_data[i];
      end
    end
  end

  if (N_SRC > 1) begin : g_rr
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rr_ptr <= WB_SRC_MLU;
      end else if (!flush && grant_valid && grant_idx != WB_SRC_PIPE) begin
        rr_ptr <= rr_next(grant_idx, N_SRC);
      end
    end
  end else begin : g_no_rr
    assign rr_ptr = WB_SRC_MLU;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regw_enable <= 1'b0;
      regw_adr    <= '0;
      reg_write   <= '0;
      wb_src      <= '0;
    end else if (flush || !grant_valid) begin
      regw_enable <= 1'b0;
      regw_adr    <= '0;
      reg_write   <= '0;
      wb_src      <= '0;
    end else begin
      regw_enable <= 1'b1;
      regw_adr    <= sel_adr;
      reg_write   <= sel_data;
      wb_src      <= grant_idx;
    end
  end

`ifdef WB_SCOREBOARD_EN
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (entry_valid[i][e]) pending_mask[entry_adr[i][e*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (regw_enable) pending_mask[regw_adr] = 1'b1;
    pending_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// compared against a list-based reference model of the writeback queues.
module tb_wb_arbiter;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_adr;
  logic [95:0] src_data;
  logic        regw_enable;
  logic [4:0]  regw_adr;
  logic [31:0] reg_write;
  logic [2:0]  wb_src;
`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending_mask;
`endif

  int checks   = 0;
  int failures = 0;

  logic [4:0]  m_adr  [N][DEPTH];
  logic [31:0] m_data [N][DEPTH];
  int          m_cnt  [N];
  int          rr_m;
  logic        exp_en;
  logic [4:0]  exp_adr;
  logic [31:0] exp_data;
  logic [2:0]  exp_src;
  logic [2:0]  last_acc;

  wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_adr      (src_adr),
    .src_data     (src_data),
    .regw_enable  (regw_enable),
    .regw_adr     (regw_adr),
    .reg_write    (reg_write),
    .wb_src       (wb_src)
`ifdef WB_SCOREBOARD_EN
    ,
    .pending_mask (pending_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic fl);
    src_valid = v;
    src_adr   = {a2, a1, a0};
    src_data  = {d2, d1, d0};
    flush     = fl;
  endtask

  task automatic model_clear(input logic rst);
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    if (rst) rr_m = 1;
    exp_en = 1'b0; exp_adr = '0; exp_data = '0; exp_src = '0;
  endtask

  // One clock edge of the reference: pick a winner from the queue heads,
  // then append whatever the sources handed over this cycle.
  task automatic model_edge();
    logic [2:0] acc;
    int g;
    int k;
    if (!reset) begin
      model_clear(1'b1);
      last_acc = '0;
      return;
    end
    for (int i = 0; i < N; i++) acc[i] = src_valid[i] && !flush && (m_cnt[i] < DEPTH);
    last_acc = acc;
    if (flush) begin
      model_clear(1'b0);
      return;
    end
    g = -1;
    if (m_cnt[0] > 0) g = 0;
    else begin
      for (int j = 0; j < N - 1; j++) begin
        k = 1 + ((rr_m - 1 + j) % (N - 1));
        if (g < 0 && m_cnt[k] > 0) g = k;
      end
    end
    if (g >= 0) begin
      exp_en = 1'b1; exp_adr = m_adr[g][0]; exp_data = m_data[g][0]; exp_src = 3'(g);
      for (int e = 0; e < DEPTH - 1; e++) begin
        m_adr[g][e]  = m_adr[g][e+1];
        m_data[g][e] = m_data[g][e+1];
      end
      m_cnt[g]--;
      if (g > 0) rr_m = (g % (N - 1)) + 1;
    end else begin
      exp_en = 1'b0; exp_adr = '0; exp_data = '0; exp_src = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_adr[i*5 +: 5] != 5'd0) begin
        m_adr[i][m_cnt[i]]  = src_adr[i*5 +: 5];
        m_data[i][m_cnt[i]] = src_data[i*32 +: 32];
        m_cnt[i]++;
      end
    end
  endtask

  function automatic logic [31:0] exp_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      for (int e = 0; e < m_cnt[i]; e++) m[m_adr[i][e]] = 1'b1;
    if (exp_en) m[exp_adr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_model_outputs();
    checkOutput("regw_enable", regw_enable, exp_en);
    checkOutput("regw_adr", regw_adr, exp_adr);
    checkOutput("reg_write", reg_write, exp_data);
    checkOutput("wb_src", wb_src, exp_src);
`ifdef WB_SCOREBOARD_EN
    checkOutput("pending_mask", pending_mask, exp_mask());
`endif
  endtask

  task automatic run_cycle();
    logic [2:0] er;
    @(negedge clk);
    for (int i = 0; i < N; i++) er[i] = reset && !flush && (m_cnt[i] < DEPTH);
    checkOutput("src_ready", src_ready, er);
    @(posedge clk);
    model_edge();
    #1;
    check_model_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      run_cycle();
    end
  endtask

  initial begin
    logic [2:0] seen [4];
    logic       accepted;
    $display("[TB] wb_arbiter bench starting");
    clk = 1'b0;
    reset = 1'b1;
    last_acc = '0;
    model_clear(1'b1);
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Power-on reset
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_enable", regw_enable, 1'b0);
    checkOutput("rst_adr", regw_adr, 5'd0);
    checkOutput("rst_data", reg_write, 32'd0);
    checkOutput("rst_src", wb_src, 3'd0);
    checkOutput("rst_ready", src_ready, 3'b000);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 checkOutput("rst_release_ready", src_ready, 3'b111);
    idle_cycles(2);

    // Latency: one push from the pipeline, visible one edge later
    applyStimulus(3'b001, 5'd8, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0, 1'b0);
    run_cycle();
    checkOutput("lat_not_yet", regw_enable, 1'b0);
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    run_cycle();
    checkOutput("lat_enable", regw_enable, 1'b1);
    checkOutput("lat_adr", regw_adr, 5'd8);
    checkOutput("lat_data", reg_write, 32'h1234);
    checkOutput("lat_src", wb_src, 3'd0);
    idle_cycles(1);

    // Round-robin between late producers: 1,2,1,2
    applyStimulus(3'b110, 5'd0, 5'd11, 5'd21, 32'd0, 32'hA1, 32'hB1, 1'b0);
    run_cycle();
    applyStimulus(3'b110, 5'd0, 5'd12, 5'd22, 32'd0, 32'hA2, 32'hB2, 1'b0);
    run_cycle();
    seen[0] = wb_src;
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int c = 1; c < 4; c++) begin
      run_cycle();
      seen[c] = wb_src;
    end
    checkOutput("rr_grant0", seen[0], 3'd1);
    checkOutput("rr_grant1", seen[1], 3'd2);
    checkOutput("rr_grant2", seen[2], 3'd1);
    checkOutput("rr_grant3", seen[3], 3'd2);
    idle_cycles(1);

    // Back-pressure: src1 fills while src0 keeps the port busy
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b011, 5'd3, 5'(10 + c), 5'd0, 32'(c), 32'(100 + c), 32'd0, 1'b0);
      run_cycle();
    end
    checkOutput("full_ready1", src_ready[1], 1'b0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(3'b011, 5'd3, 5'd14, 5'd0, 32'(9 + c), 32'd104, 32'd0, 1'b0);
      run_cycle();
      checkOutput("full_starve_src", wb_src, 3'd0);
    end
    accepted = 1'b0;
    for (int c = 0; c < 10 && !accepted; c++) begin
      applyStimulus(3'b010, 5'd0, 5'd14, 5'd0, 32'd0, 32'd104, 32'd0, 1'b0);
      run_cycle();
      accepted = last_acc[1];
    end
    checkOutput("full_fifth_accepted", accepted, 1'b1);
    idle_cycles(8);

    // Register 0 write is swallowed
    applyStimulus(3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF, 1'b0);
    run_cycle();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      run_cycle();
      checkOutput("zero_no_write", regw_enable, 1'b0);
`ifdef WB_SCOREBOARD_EN
      checkOutput("zero_mask_bit0", pending_mask[0], 1'b0);
`endif
    end

    // Flush with queued entries and a live input
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b111, 5'd4, 5'(16 + c), 5'(24 + c), 32'(c), 32'(200 + c), 32'(300 + c), 1'b0);
      run_cycle();
    end
    applyStimulus(3'b111, 5'd31, 5'd31, 5'd31, 32'hDEAD, 32'hDEAD, 32'hDEAD, 1'b1);
    run_cycle();
    checkOutput("flush_no_write", regw_enable, 1'b0);
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1 checkOutput("flush_ready", src_ready, 3'b111);
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      checkOutput("flush_dropped", regw_enable, 1'b0);
    end

    // Asynchronous reset in the middle of traffic
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b011, 5'd6, 5'(1 + c), 5'd0, 32'(c), 32'(400 + c), 32'd0, 1'b0);
      run_cycle();
    end
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_clear(1'b1);
    checkOutput("midrst_enable", regw_enable, 1'b0);
    checkOutput("midrst_adr", regw_adr, 5'd0);
    checkOutput("midrst_ready", src_ready, 3'b000);
    @(posedge clk);
    #1 checkOutput("midrst_hold", regw_enable, 1'b0);
    reset = 1'b1;
    #1 checkOutput("midrst_release_ready", src_ready, 3'b111);
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      checkOutput("midrst_no_stale", regw_enable, 1'b0);
    end

    // Random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      applyStimulus(3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    $urandom, $urandom, $urandom, ($urandom_range(0, 39) == 0));
      run_cycle();
    end
    idle_cycles(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
